mult8x8_seq_ctrl: RTL and testbench
===================================

// Module: mult8x8_seq_ctrl
// PURPOSE
//   Sequencer + accumulator for the sequential 8x8 multiplier.
//   Drives the 2-bit nibble-select into the nibble mux.
//   Takes the 2N-bit partial product from the NxN multiplier fed by that mux.
//   Shifts and accumulates four partials into a 4N-bit product, with start/done handshake.
//   Operands are not latched here: upstream holds dataa/datab stable from start until done.
// PARAMETERS
//   N  4  nibble width; operand = 2N bits, partial = 2N bits, product = 4N bits
// PORTS
//   clk          in   1     rising-edge clock
//   reset_n      in   1     asynchronous active-low reset
//   start        in   1     request new multiply; sampled in IDLE or DONE only
//   partial      in   2N    combinational product of currently selected nibbles
//   sel          out  2     nibble select; sel[1]=A nibble (0 lo/1 hi), sel[0]=B nibble
//   busy         out  1     high while in CALC
//   done         out  1     high in DONE; product valid
//   product      out  4N    accumulated result register
// BEHAVIOUR
//   Reset (async, reset_n=0), applies immediately at any point:
//     state=IDLE, cnt=0, product=0, sel=2'b00, busy=0, done=0.
//   States:
//     IDLE: start=1 -> product<=0, cnt<=0, go CALC; else stay.
//     CALC: each edge: product <= product + (partial << shift), cnt<=cnt+1.
//       On the edge where cnt==3, go DONE (cnt<=0).
//     DONE: done=1, product held.
//       start=1 -> product<=0, cnt<=0, go CALC (done drops next cycle).
//       else stay in DONE indefinitely.
//   sel:
//     sel = cnt (2-bit counter, registered) while in CALC; 2'b00 otherwise.
//     Glitch-free, stable for the whole cycle.
//     Order: 00 (Alo*Blo), 01 (Alo*Bhi), 10 (Ahi*Blo), 11 (Ahi*Bhi).
//   Shift:
//     shift = N*(sel[1]+sel[0]), i.e. 0, N, N, 2N.
//     Partial is zero-extended to 4N bits before the shift.
//     Add is 4N bits wide; cannot overflow (max (2^2N-1)^2 < 2^4N).
//   Latency:
//     start sampled at edge E0 -> four accumulate edges E1..E4.
//     done=1 and product final after E4.
//     Start-to-done = 5 edges; done is a level, not a pulse.
//   busy = (state==CALC); done = (state==DONE). Both decoded from registered state.
//   start while CALC: ignored; no restart, no effect on result.
//   start held high continuously: after DONE, a new multiply begins next edge.
//     DONE lasts exactly one cycle.
//   Reset mid-CALC: result discarded, IDLE; next start begins a fresh multiply.
//   Unused state encodings recover to IDLE on the next edge.
// TESTING
//   1 A=0xFF,B=0xFF, start pulse -> sel 00,01,10,11 over E1..E4; done after E4; product=0xFE01.
//   2 A=0x12,B=0x34 -> product=0x03A8; busy high exactly 4 cycles, done stays high until next start.
//   3 A=0x00,B=0xA5 -> product=0x0000; then A=0x80,B=0x02 restart from DONE -> product=0x0100.
//   4 start re-pulsed during CALC (cycle 2) with A=0x0F,B=0x0F -> ignored; done after E4, product=0x00E1.
//   5 reset_n low mid-CALC (after E2) -> immediately product=0, sel=00, busy=0, done=0;
//     new start with A=0x10,B=0x10 -> product=0x0100.
//   6 start tied high, A=0x03,B=0x05 -> repeated 0x000F results; done high 1 cycle every 5 cycles.

Source files
------------

// File: rtl/mult8x8_seq_ctrl.sv
// mult8x8_seq_ctrl
//   Sequencer and accumulator for a sequential 2N x 2N multiplier built around
//   one N x N multiplier. Each CALC cycle selects one nibble pair, takes the
//   resulting 2N-bit partial product, aligns it and adds it into a 4N-bit
//   product register. Four CALC cycles complete one multiply. Operands live
//   upstream and must stay stable from start until done.
//
// Ports
//   clk      in   1    rising-edge clock
//   reset_n  in   1    asynchronous active-low reset
//   start    in   1    begin a multiply; honoured in IDLE or DONE only
//   partial  in   2N   product of the nibbles currently chosen by sel
//   sel      out  2    nibble select: sel[1] = A nibble, sel[0] = B nibble
//   busy     out  1    high while accumulating
//   done     out  1    high while the product is final (a level)
//   product  out  4N   accumulated result register
module mult8x8_seq_ctrl #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [2*N-1:0] partial,
    output logic [1:0]     sel,
    output logic           busy,
    output logic           done,
    output logic [4*N-1:0] product
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t         state, state_nxt;
    logic [1:0]     cnt, cnt_nxt;
    logic [4*N-1:0] product_nxt;

    // Zero-extend the partial and place it by nibble weight:
    // lo*lo -> 0, mixed -> N, hi*hi -> 2N.
    function automatic logic [4*N-1:0] align_partial(input logic [2*N-1:0] p,
                                                     input logic [1:0]     s);
        logic [4*N-1:0] ext;
        ext = {{(2*N){1'b0}}, p};
        case (s)
            2'b00:   return ext;
            2'b11:   return ext << (2*N);
            default: return ext << N;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= 2'd0;
            product <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            product <= product_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        product_nxt = product;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    product_nxt = '0;
                    cnt_nxt     = 2'd0;
                    state_nxt   = S_CALC;
                end
            end
            S_CALC: begin
                // start is deliberately not looked at here.
                product_nxt = product + align_partial(partial, cnt);
                if (cnt == 2'd3) begin
                    cnt_nxt   = 2'd0;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 2'd0;
            end
        endcase
    end

    // cnt is cleared on every exit from CALC, so it already reads 00 outside
    // CALC; driving sel straight from the register keeps it glitch-free.
    assign sel  = cnt;
    assign busy = (state == S_CALC);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
module tb_mult8x8_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  opa, opb;
    logic [7:0]  partial;
    logic [1:0]  sel;
    logic        busy, done;
    logic [15:0] product;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    mult8x8_seq_ctrl #(.N(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .partial (partial),
        .sel     (sel),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // Environment: nibble mux feeding a 4x4 multiplier.
    assign partial = (sel[1] ? opa[7:4] : opa[3:0]) * (sel[0] ? opb[7:4] : opb[3:0]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // m_k = 0 when not calculating, else the index (1..4) of the calc cycle.
    int          m_k;
    bit          m_done;
    logic [15:0] m_prod;

    function automatic logic [15:0] term(input int k, input logic [7:0] a, input logic [7:0] b);
        int al, ah, bl, bh;
        al = a % 16; ah = a / 16; bl = b % 16; bh = b / 16;
        case (k)
            0:       return 16'(al * bl);
            1:       return 16'(al * bh * 16);
            2:       return 16'(ah * bl * 16);
            default: return 16'(ah * bh * 256);
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_k = 0; m_done = 0; m_prod = 16'h0;
        end else if (m_k > 0) begin
            m_prod = m_prod + term(m_k - 1, opa, opb);
            if (m_k == 4) begin m_k = 0; m_done = 1; end
            else m_k = m_k + 1;
        end else if (start) begin
            m_prod = 16'h0; m_k = 1; m_done = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en && reset_n) begin
            chk("busy", busy, (m_k > 0));
            chk("done", done, m_done && m_k == 0);
            chk("sel", sel, (m_k > 0) ? 32'(m_k - 1) : 32'd0);
            chk("product", product, m_prod);
        end
    end

    // ---------------- directed stimulus ----------------
    int         bcnt;
    logic [7:0] selseq;

    // Called at a negedge; returns at the first negedge where done is seen.
    task automatic do_mult(input logic [7:0] a, input logic [7:0] b);
        int g;
        opa = a; opb = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bcnt = 0; selseq = 8'h0; g = 0;
        while (!done && g < 10) begin
            if (busy) begin
                bcnt++;
                selseq = {selseq[5:0], sel};
            end
            @(negedge clk);
            g++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int dcnt;
        reset_n = 1'b0; start = 1'b0; opa = 8'h0; opb = 8'h0;
        repeat (2) @(negedge clk);
        chk("rst_product", product, 16'h0);
        chk("rst_sel", sel, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        @(negedge clk);

        // 1: FF*FF, sel order and latency
        do_mult(8'hFF, 8'hFF);
        chk("t1_product", product, 16'hFE01);
        chk("t1_selseq", selseq, 8'h1B);
        chk("t1_busy_cycles", bcnt, 4);

        // 2: 12*34, done persists
        do_mult(8'h12, 8'h34);
        chk("t2_product", product, 16'h03A8);
        chk("t2_busy_cycles", bcnt, 4);
        repeat (3) @(negedge clk);
        chk("t2_done_hold", done, 1'b1);
        chk("t2_product_hold", product, 16'h03A8);

        // 3: zero operand, then restart from DONE
        do_mult(8'h00, 8'hA5);
        chk("t3a_product", product, 16'h0000);
        do_mult(8'h80, 8'h02);
        chk("t3b_product", product, 16'h0100);

        // 4: start re-pulsed mid-calc is ignored
        opa = 8'h0F; opb = 8'h0F; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_done", done, 1'b1);
        chk("t4_product", product, 16'h00E1);
        repeat (2) @(negedge clk);
        chk("t4_no_restart", busy, 1'b0);

        // 5: reset mid-calc, then fresh multiply
        opa = 8'h55; opb = 8'h55; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_product", product, 16'h0);
        chk("t5_rst_sel", sel, 2'b00);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_done", done, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_mult(8'h10, 8'h10);
        chk("t5_product", product, 16'h0100);

        // 6: start held high, back-to-back multiplies
        opa = 8'h03; opb = 8'h05; start = 1'b1;
        dcnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) begin
                dcnt++;
                chk("t6_product", product, 16'h000F);
            end
        end
        chk("t6_done_count", dcnt, 3);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_final_done", done, 1'b1);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
